switch_send_queue: RTL
======================

# switch_send_queue

Per-core outbound buffer between a vector core and the shared crossbar switch. The core pushes (destination core, vector) entries; the queue holds up to DEPTH of them and drives the switch's send handshake from the head entry, popping on send_ok. This decouples core issue from switch arbitration, so a core can issue back-to-back sends without stalling on contention.

## Interface
- CORE_SIZE, 2, number of cores on the switch
- WIDTH, 16, shortreal lanes per vector (matches switch WIDTH)
- DEPTH, 4, entries held; any value ≥ 1
- CORE_ADDR_SIZE, $clog2(CORE_SIZE), auto-gen, destination index width
- COUNT_SIZE, $clog2(DEPTH+1), auto-gen, occupancy width
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- push_valid  in  1  core offers an entry this cycle
- push_core_idx  in  CORE_ADDR_SIZE  destination core of the offered entry
- push_data  in  shortreal[WIDTH]  vector payload of the offered entry
- push_ready  out  1  queue can accept an entry this cycle
- send_ready  out  1  head entry valid; to switch send_ready
- send_core_idx  out  CORE_ADDR_SIZE  head destination; to switch send_core_idx
- send_data  out  shortreal[WIDTH]  head payload; to switch send_data
- send_ok  in  1  switch accepts the head entry this cycle
- count  out  COUNT_SIZE  entries currently held
- empty  out  1  count == 0
- stall_cycles  out  16  saturating count of cycles with send_ready=1 and send_ok=0

## Operation
- Storage: DEPTH-entry circular buffer of {core_idx, data}; rd_ptr, wr_ptr wrap from DEPTH-1 to 0; count tracks occupancy.
- Push: fires when push_valid && push_ready; entry written at wr_ptr, wr_ptr advances. push_valid with push_ready=0 is a stall, not an error; nothing written.
- Pop: fires when send_ready && send_ok; rd_ptr advances. send_ok while send_ready=0 is ignored.
- push_ready = (count != DEPTH). Does not depend on send_ok (no combinational path switch→core); a full queue refuses a push even in a cycle it pops.
- Push and pop in the same cycle: both happen, count unchanged.
- send_ready = !empty; send_core_idx/send_data are the rd_ptr entry, held stable until popped.
- Entries leave in push order; no reordering by destination.
- stall_cycles increments by 1 each cycle send_ready && !send_ok, saturates at 16'hFFFF, never clears except by reset.

## Timing
- Reset (low, asynchronous): rd_ptr=wr_ptr=0, count=0, empty=1, push_ready=1, send_ready=0, send_core_idx=0, send_data all 0.0, all storage 0.0/0, stall_cycles=0. Reset mid-transfer discards all held entries; no partial send survives.
- Push-to-send latency: entry pushed at edge N appears on send_* with send_ready=1 after edge N (visible cycle N+1), even if queue was empty.
- Pop takes effect at the edge where send_ok is sampled high; next entry (if any) is presented the following cycle, so back-to-back send_ok drains one entry per cycle.
- count/empty/push_ready update at the same edge as the push/pop that changes them.

## Structure
- Shared package switch_pkg: default CORE_SIZE/WIDTH constants and the typedef for a send entry struct {core_idx, data[WIDTH]}; Switch, VecCore and this queue all import it.
- Sub-module sat_counter (parameterised width, increment enable, saturate at all-ones) for stall_cycles; storage and pointers inline.

## Test plan
- Reset: hold reset low mid-stream with 3 entries held -> count=0, empty=1, send_ready=0, send_data all 0.0, stall_cycles=0 immediately, without a clock edge.
- Single send: push {idx=1, data[i]=i*1.0}, send_ok tied high -> send_ready high one cycle later with idx=1, data intact; popped at that edge; empty=1 next cycle.
- Fill/full: DEPTH=4, send_ok=0, push 5 entries back-to-back -> push_ready low after 4th, 5th held off, count=4, stall_cycles increments each cycle send_ready=1.
- Full with simultaneous pop: full queue, push_valid=1 and send_ok=1 same cycle -> pop only, count=3; push accepted next cycle, count back to 4.
- Order and wrap: 10 entries with idx alternating 0/1, send_ok random 50% -> switch observes all 10 in push order, payloads exact, pointers wrap twice without loss.
- Saturation: send_ok=0 for 70000 cycles with one entry held -> stall_cycles = 16'hFFFF and stays there.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch types: default geometry and the send-entry payload.
package switch_pkg;

   localparam int unsigned CORE_SIZE      = 2;
   localparam int unsigned WIDTH          = 16;
   localparam int unsigned LANE_W         = 32;
   localparam int unsigned CORE_ADDR_SIZE = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1;

   // A lane carries the IEEE-754 single-precision bit pattern of one shortreal.
   typedef logic [LANE_W-1:0]         lane_t;
   typedef lane_t [WIDTH-1:0]         vec_t;
   typedef logic [CORE_ADDR_SIZE-1:0] core_idx_t;

   typedef struct packed {
      core_idx_t core_idx;
      vec_t      data;
   } send_entry_t;

endpackage

// File: rtl/switch_send_queue_if.sv
// Core push port and switch send port of the per-core send queue.
interface switch_send_queue_if;
   import switch_pkg::*;

   logic      push_valid;
   core_idx_t push_core_idx;
   vec_t      push_data;
   logic      push_ready;

   logic      send_ready;
   core_idx_t send_core_idx;
   vec_t      send_data;
   logic      send_ok;

   // Environment side: core pushes, switch accepts.
   modport master (
      output push_valid, push_core_idx, push_data, send_ok,
      input  push_ready, send_ready, send_core_idx, send_data
   );

   // Queue side.
   modport slave (
      input  push_valid, push_core_idx, push_data, send_ok,
      output push_ready, send_ready, send_core_idx, send_data
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: hold at all-ones once reached.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/switch_send_queue.sv
// Per-core outbound FIFO feeding the crossbar send handshake from its head.
module switch_send_queue
   import switch_pkg::*;
#(
   parameter  int unsigned DEPTH      = 4,
   localparam int unsigned COUNT_SIZE = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   switch_send_queue_if.slave    q_if,
   output logic [COUNT_SIZE-1:0] count_o,
   output logic                  empty_o,
   output logic [15:0]           stall_cycles_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   send_entry_t           mem_q [DEPTH];
   send_entry_t           push_entry;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [COUNT_SIZE-1:0] count_q, count_d;
   logic                  push_fire, pop_fire;
   logic                  not_full, not_empty;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake decode; push_ready depends only on held state, never on send_ok.
   always_comb begin
      not_full   = (count_q != COUNT_SIZE'(DEPTH));
      not_empty  = (count_q != '0);
      push_fire  = q_if.push_valid && not_full;
      pop_fire   = not_empty && q_if.send_ok;
      push_entry = '{core_idx: q_if.push_core_idx, data: q_if.push_data};
   end

   // Pointer and occupancy next state; simultaneous push+pop leaves count unchanged.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_fire)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + COUNT_SIZE'(1);
         2'b01:   count_d = count_q - COUNT_SIZE'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; reset wipes every slot so no stale payload survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push_fire) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   sat_counter #(.W(16)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (not_empty && !q_if.send_ok),
      .cnt_o (stall_cycles_o)
   );

   assign q_if.push_ready    = not_full;
   assign q_if.send_ready    = not_empty;
   assign q_if.send_core_idx = mem_q[rd_ptr_q].core_idx;
   assign q_if.send_data     = mem_q[rd_ptr_q].data;
   assign count_o            = count_q;
   assign empty_o            = !not_empty;

endmodule
